// File: rtl/ip_pipe_pkg.sv
// Shared definitions for the integer pipeline: branch types, ALU op codes
// and the default datapath width.
package ip_pipe_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    BT_NONE  = 2'd0,
    BT_JAL   = 2'd1,
    BT_JALR  = 2'd2,
    BT_BCOND = 2'd3
  } br_type_e;

  // ALU op codes; the option bit selects SUB for ADD and SRA for SRL.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SEQ  = 4'd8;

endpackage

// File: rtl/ip_br_resolve.sv
// Combinational branch resolution: target address, taken decision and
// misprediction against the fetch-time prediction.
module ip_br_resolve
  import ip_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      br_type,
  input  logic            br_neg,
  input  logic [XLEN-1:0] br_base,
  input  logic [20:0]     br_offset,
  input  logic            alu_lsb,
  input  logic            bp,
  input  logic [XLEN-1:0] bt,
  output logic [XLEN-1:0] target,
  output logic            mispredict
);

  logic [XLEN-1:0] sum;
  logic            taken;
  br_type_e        bt_e;

  assign bt_e = br_type_e'(br_type);

  // Target is base plus sign-extended offset with bit 0 forced low; a
  // conditional branch is taken when the ALU compare bit (optionally
  // inverted) is set.
  always_comb begin
    sum    = br_base + XLEN'($signed(br_offset));
    target = {sum[XLEN-1:1], 1'b0};
    case (bt_e)
      BT_JAL, BT_JALR: taken = 1'b1;
      BT_BCOND:        taken = alu_lsb ^ br_neg;
      default:         taken = 1'b0;
    endcase
    mispredict = (taken != bp) || (taken && (target != bt));
  end

endmodule

// File: rtl/ip_pipe.sv
// Integer execute pipeline: one ALU/branch op per cycle, LATENCY result
// stages with per-stage forwarding, global stall on writeback back-pressure,
// flush, and a one-cycle fetch redirect on branch misprediction.
//
// Handshakes: an issue transfer happens on a clock edge where ix_ip_valid and
// ix_ip_ready are both 1; a retirement happens on an edge where ip_wb_valid
// and ip_wb_ready are both 1. ix_ip_ready never depends on ix_ip_valid, and
// ip_wb_valid never depends on ip_wb_ready.
module ip_pipe
  import ip_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int LATENCY = 1,
  parameter int BR_EN   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [XLEN-1:0]         ix_ip_pc,
  input  logic [4:0]              ix_ip_dst,
  input  logic                    ix_ip_wb_en,
  input  logic [3:0]              ix_ip_op,
  input  logic                    ix_ip_option,
  input  logic                    ix_ip_truncate,
  input  logic [1:0]              ix_ip_br_type,
  input  logic                    ix_ip_br_neg,
  input  logic [XLEN-1:0]         ix_ip_br_base,
  input  logic [20:0]             ix_ip_br_offset,
  input  logic [XLEN-1:0]         ix_ip_operand1,
  input  logic [XLEN-1:0]         ix_ip_operand2,
  input  logic                    ix_ip_bp,
  input  logic [XLEN-1:0]         ix_ip_bt,
  input  logic                    ix_ip_valid,
  output logic                    ix_ip_ready,
  output logic [LATENCY-1:0]      ip_ix_fwd_valid,
  output logic [5*LATENCY-1:0]    ip_ix_fwd_dst,
  output logic [XLEN*LATENCY-1:0] ip_ix_fwd_data,
  output logic [4:0]              ip_wb_dst,
  output logic [XLEN-1:0]         ip_wb_result,
  output logic [XLEN-1:0]         ip_wb_pc,
  output logic                    ip_wb_wb_en,
  output logic                    ip_wb_valid,
  input  logic                    ip_wb_ready,
  output logic                    ip_if_pc_override,
  output logic [XLEN-1:0]         ip_if_new_pc
);

  localparam int  SHW      = $clog2(XLEN);
  localparam bit  TRUNC_OK = (XLEN == 64);

  logic [LATENCY-1:0]            vld_q, vld_d, wben_q, wben_d;
  logic [LATENCY-1:0][4:0]       dst_q, dst_d;
  logic [LATENCY-1:0][XLEN-1:0]  pc_q, pc_d, res_q, res_d;
  logic                          ovr_q, ovr_d;
  logic [XLEN-1:0]               new_pc_q, new_pc_d;

  logic            advance, transfer;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_raw, alu_res;
  logic [XLEN-1:0] br_target;
  logic            br_mispredict;

  assign advance     = !vld_q[LATENCY-1] || ip_wb_ready;
  assign transfer    = ix_ip_valid && advance;
  assign ix_ip_ready = advance;
  assign shamt       = ix_ip_operand2[SHW-1:0];

  // ALU for the op being offered this cycle.
  always_comb begin
    alu_raw = '0;
    case (ix_ip_op)
      ALU_ADD:  alu_raw = ix_ip_option ? (ix_ip_operand1 - ix_ip_operand2)
                                       : (ix_ip_operand1 + ix_ip_operand2);
      ALU_SLL:  alu_raw = ix_ip_operand1 << shamt;
      ALU_SLT:  alu_raw = {{(XLEN-1){1'b0}},
                           ($signed(ix_ip_operand1) < $signed(ix_ip_operand2))};
      ALU_SLTU: alu_raw = {{(XLEN-1){1'b0}}, (ix_ip_operand1 < ix_ip_operand2)};
      ALU_XOR:  alu_raw = ix_ip_operand1 ^ ix_ip_operand2;
      ALU_SRL:  alu_raw = ix_ip_option ? XLEN'($signed(ix_ip_operand1) >>> shamt)
                                       : (ix_ip_operand1 >> shamt);
      ALU_OR:   alu_raw = ix_ip_operand1 | ix_ip_operand2;
      ALU_AND:  alu_raw = ix_ip_operand1 & ix_ip_operand2;
      ALU_SEQ:  alu_raw = {{(XLEN-1){1'b0}}, (ix_ip_operand1 == ix_ip_operand2)};
      default:  alu_raw = '0;
    endcase
    alu_res = (TRUNC_OK && ix_ip_truncate) ? XLEN'($signed(alu_raw[31:0])) : alu_raw;
  end

  if (BR_EN != 0) begin : g_br
    ip_br_resolve #(.XLEN(XLEN)) u_br_resolve (
      .br_type    (ix_ip_br_type),
      .br_neg     (ix_ip_br_neg),
      .br_base    (ix_ip_br_base),
      .br_offset  (ix_ip_br_offset),
      .alu_lsb    (alu_res[0]),
      .bp         (ix_ip_bp),
      .bt         (ix_ip_bt),
      .target     (br_target),
      .mispredict (br_mispredict)
    );
  end else begin : g_no_br
    assign br_target     = '0;
    assign br_mispredict = 1'b0;
  end

  // Stage shift on advance; an op accepted while a redirect is showing is
  // wrong-path and enters as a bubble. Flush wins over everything.
  always_comb begin
    vld_d  = vld_q;
    wben_d = wben_q;
    dst_d  = dst_q;
    pc_d   = pc_q;
    res_d  = res_q;
    if (advance) begin
      vld_d[0]  = transfer && !ovr_q;
      wben_d[0] = ix_ip_wb_en;
      dst_d[0]  = ix_ip_dst;
      pc_d[0]   = ix_ip_pc;
      res_d[0]  = alu_res;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k]  = vld_q[k-1];
        wben_d[k] = wben_q[k-1];
        dst_d[k]  = dst_q[k-1];
        pc_d[k]   = pc_q[k-1];
        res_d[k]  = res_q[k-1];
      end
    end
    if (flush) vld_d = '0;
  end

  // Redirect pulse: only for a live (non wrong-path) branch transfer, never
  // on a flush edge; it lasts exactly one cycle.
  always_comb begin
    ovr_d    = 1'b0;
    new_pc_d = new_pc_q;
    if (transfer && !ovr_q && !flush && (ix_ip_br_type != BT_NONE) && br_mispredict) begin
      ovr_d    = 1'b1;
      new_pc_d = br_target;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wben_q   <= '0;
      dst_q    <= '0;
      pc_q     <= '0;
      res_q    <= '0;
      ovr_q    <= 1'b0;
      new_pc_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wben_q   <= wben_d;
      dst_q    <= dst_d;
      pc_q     <= pc_d;
      res_q    <= res_d;
      ovr_q    <= ovr_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign ip_ix_fwd_valid   = vld_q & wben_q;
  assign ip_ix_fwd_dst     = dst_q;
  assign ip_ix_fwd_data    = res_q;
  assign ip_wb_valid       = vld_q[LATENCY-1];
  assign ip_wb_wb_en       = wben_q[LATENCY-1];
  assign ip_wb_dst         = dst_q[LATENCY-1];
  assign ip_wb_pc          = pc_q[LATENCY-1];
  assign ip_wb_result      = res_q[LATENCY-1];
  assign ip_if_pc_override = ovr_q;
  assign ip_if_new_pc      = new_pc_q;

endmodule

// File: tb/tb_ip_pipe.sv
// Bench for ip_pipe (XLEN=64, LATENCY=3, BR_EN=1): directed scenarios then
// random traffic, checked against an in-order retirement model.
module tb_ip_pipe;
  import ip_pipe_pkg::*;

  localparam int XLEN    = 64;
  localparam int LATENCY = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    flush;
  logic [XLEN-1:0]         ix_ip_pc;
  logic [4:0]              ix_ip_dst;
  logic                    ix_ip_wb_en;
  logic [3:0]              ix_ip_op;
  logic                    ix_ip_option;
  logic                    ix_ip_truncate;
  logic [1:0]              ix_ip_br_type;
  logic                    ix_ip_br_neg;
  logic [XLEN-1:0]         ix_ip_br_base;
  logic [20:0]             ix_ip_br_offset;
  logic [XLEN-1:0]         ix_ip_operand1;
  logic [XLEN-1:0]         ix_ip_operand2;
  logic                    ix_ip_bp;
  logic [XLEN-1:0]         ix_ip_bt;
  logic                    ix_ip_valid;
  logic                    ix_ip_ready;
  logic [LATENCY-1:0]      ip_ix_fwd_valid;
  logic [5*LATENCY-1:0]    ip_ix_fwd_dst;
  logic [XLEN*LATENCY-1:0] ip_ix_fwd_data;
  logic [4:0]              ip_wb_dst;
  logic [XLEN-1:0]         ip_wb_result;
  logic [XLEN-1:0]         ip_wb_pc;
  logic                    ip_wb_wb_en;
  logic                    ip_wb_valid;
  logic                    ip_wb_ready;
  logic                    ip_if_pc_override;
  logic [XLEN-1:0]         ip_if_new_pc;

  ip_pipe #(.XLEN(XLEN), .LATENCY(LATENCY), .BR_EN(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .ix_ip_pc          (ix_ip_pc),
    .ix_ip_dst         (ix_ip_dst),
    .ix_ip_wb_en       (ix_ip_wb_en),
    .ix_ip_op          (ix_ip_op),
    .ix_ip_option      (ix_ip_option),
    .ix_ip_truncate    (ix_ip_truncate),
    .ix_ip_br_type     (ix_ip_br_type),
    .ix_ip_br_neg      (ix_ip_br_neg),
    .ix_ip_br_base     (ix_ip_br_base),
    .ix_ip_br_offset   (ix_ip_br_offset),
    .ix_ip_operand1    (ix_ip_operand1),
    .ix_ip_operand2    (ix_ip_operand2),
    .ix_ip_bp          (ix_ip_bp),
    .ix_ip_bt          (ix_ip_bt),
    .ix_ip_valid       (ix_ip_valid),
    .ix_ip_ready       (ix_ip_ready),
    .ip_ix_fwd_valid   (ip_ix_fwd_valid),
    .ip_ix_fwd_dst     (ip_ix_fwd_dst),
    .ip_ix_fwd_data    (ip_ix_fwd_data),
    .ip_wb_dst         (ip_wb_dst),
    .ip_wb_result      (ip_wb_result),
    .ip_wb_pc          (ip_wb_pc),
    .ip_wb_wb_en       (ip_wb_wb_en),
    .ip_wb_valid       (ip_wb_valid),
    .ip_wb_ready       (ip_wb_ready),
    .ip_if_pc_override (ip_if_pc_override),
    .ip_if_new_pc      (ip_if_new_pc)
  );

  // ---------------- stimulus record and model ----------------
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  dst;
    logic        wb_en;
    logic [3:0]  op;
    logic        option;
    logic        trunc;
    logic [1:0]  br_type;
    logic        br_neg;
    logic [63:0] base;
    logic [20:0] off;
    logic [63:0] a;
    logic [63:0] b;
    logic        bp;
    logic [63:0] bt;
  } op_t;

  // An in-flight op: cnt is how many stage positions it has reached (1 = S0).
  typedef struct packed {
    logic [4:0]  dst;
    logic        wb_en;
    logic [63:0] pc;
    logic [63:0] result;
    logic [2:0]  cnt;
  } item_t;

  item_t       exp_q[$];
  logic        ovr_m;
  logic [63:0] new_pc_m;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] ref_alu(input op_t o);
    logic [63:0] r;
    case (o.op)
      ALU_ADD:  r = o.option ? o.a - o.b : o.a + o.b;
      ALU_SLL:  r = o.a << o.b[5:0];
      ALU_SLT:  r = ($signed(o.a) < $signed(o.b)) ? 64'd1 : 64'd0;
      ALU_SLTU: r = (o.a < o.b) ? 64'd1 : 64'd0;
      ALU_XOR:  r = o.a ^ o.b;
      ALU_SRL:  r = o.option ? 64'($signed(o.a) >>> o.b[5:0]) : o.a >> o.b[5:0];
      ALU_OR:   r = o.a | o.b;
      ALU_AND:  r = o.a & o.b;
      ALU_SEQ:  r = (o.a == o.b) ? 64'd1 : 64'd0;
      default:  r = 64'd0;
    endcase
    if (o.trunc) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic logic [63:0] ref_target(input op_t o);
    logic [63:0] t;
    t = o.base + {{43{o.off[20]}}, o.off};
    t[0] = 1'b0;
    return t;
  endfunction

  function automatic logic ref_mispredict(input op_t o);
    logic taken;
    logic [63:0] r;
    r = ref_alu(o);
    if (o.br_type == BT_JAL || o.br_type == BT_JALR) taken = 1'b1;
    else if (o.br_type == BT_BCOND)                  taken = r[0] ^ o.br_neg;
    else                                             taken = 1'b0;
    return (taken != o.bp) || (taken && ref_target(o) != o.bt);
  endfunction

  function automatic op_t mk_alu(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] dst,
                                 input logic [63:0] pc);
    op_t o;
    o = '0;
    o.op = op; o.a = a; o.b = b; o.dst = dst; o.wb_en = 1'b1; o.pc = pc;
    return o;
  endfunction

  op_t cur;

  // ---------------- driver tasks ----------------
  task automatic drive(input op_t o, input logic v);
    cur            = o;
    ix_ip_valid    = v;
    ix_ip_pc       = o.pc;
    ix_ip_dst      = o.dst;
    ix_ip_wb_en    = o.wb_en;
    ix_ip_op       = o.op;
    ix_ip_option   = o.option;
    ix_ip_truncate = o.trunc;
    ix_ip_br_type  = o.br_type;
    ix_ip_br_neg   = o.br_neg;
    ix_ip_br_base  = o.base;
    ix_ip_br_offset = o.off;
    ix_ip_operand1 = o.a;
    ix_ip_operand2 = o.b;
    ix_ip_bp       = o.bp;
    ix_ip_bt       = o.bt;
  endtask

  task automatic idle();
    drive('0, 1'b0);
  endtask

  // One clock: check pre-edge outputs against the model, advance the model
  // across the edge, then check the redirect registered by that edge.
  // Called just after a rising edge; returns just after the next one.
  task automatic cycle();
    logic        exp_wbv, adv, acc, fire, hit;
    logic [LATENCY-1:0] exp_fv;
    item_t       it;
    #1;
    exp_wbv = (exp_q.size() != 0) && (exp_q[0].cnt == 3'(LATENCY));
    chk("wb_valid", ip_wb_valid, exp_wbv);
    if (exp_wbv) begin
      chk("wb_dst",    ip_wb_dst,    exp_q[0].dst);
      chk("wb_result", ip_wb_result, exp_q[0].result);
      chk("wb_pc",     ip_wb_pc,     exp_q[0].pc);
      chk("wb_wb_en",  ip_wb_wb_en,  exp_q[0].wb_en);
    end
    adv = !exp_wbv || ip_wb_ready;
    chk("ix_ready", ix_ip_ready, adv);
    exp_fv = '0;
    for (int k = 0; k < LATENCY; k++) begin
      hit = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].cnt == 3'(k + 1)) begin hit = 1'b1; it = exp_q[i]; end
      if (hit && it.wb_en) begin
        exp_fv[k] = 1'b1;
        chk("fwd_dst",  ip_ix_fwd_dst[5*k +: 5],   it.dst);
        chk("fwd_data", ip_ix_fwd_data[64*k +: 64], it.result);
      end
    end
    chk("fwd_valid", ip_ix_fwd_valid, exp_fv);
    acc  = ix_ip_valid && adv;
    fire = acc && !flush && !ovr_m && (cur.br_type != BT_NONE) && ref_mispredict(cur);
    if (exp_wbv && ip_wb_ready) void'(exp_q.pop_front());
    if (flush) exp_q.delete();
    else if (adv) begin
      foreach (exp_q[i]) begin it = exp_q[i]; it.cnt = it.cnt + 3'd1; exp_q[i] = it; end
      if (acc && !ovr_m) begin
        it.dst = cur.dst; it.wb_en = cur.wb_en; it.pc = cur.pc;
        it.result = ref_alu(cur); it.cnt = 3'd1;
        exp_q.push_back(it);
      end
    end
    ovr_m = fire;
    if (fire) new_pc_m = ref_target(cur);
    @(posedge clk);
    #1;
    chk("override", ip_if_pc_override, ovr_m);
    if (ovr_m) chk("new_pc", ip_if_new_pc, new_pc_m);
  endtask

  task automatic random_op(output op_t o);
    logic [3:0] ops[9];
    ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND, ALU_SEQ};
    o = '0;
    o.op      = ops[$urandom_range(0, 8)];
    o.option  = 1'($urandom_range(0, 1));
    o.trunc   = ($urandom_range(0, 3) == 0);
    o.a       = {$urandom, $urandom};
    o.b       = ($urandom_range(0, 3) == 0) ? o.a : {$urandom, $urandom};
    o.dst     = 5'($urandom_range(0, 31));
    o.wb_en   = ($urandom_range(0, 3) != 0);
    o.pc      = {32'd0, $urandom} & ~64'd3;
    o.br_type = ($urandom_range(0, 1) == 0) ? 2'(BT_NONE) : 2'($urandom_range(1, 3));
    o.br_neg  = 1'($urandom_range(0, 1));
    o.base    = {32'd0, $urandom};
    o.off     = 21'($urandom);
    o.bp      = 1'($urandom_range(0, 1));
    o.bt      = ($urandom_range(0, 1) == 0) ? ref_target(o) : ref_target(o) + 64'd8;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    op_t o;
    logic acc;
    flush = 1'b0; ip_wb_ready = 1'b1; ovr_m = 1'b0; new_pc_m = '0;
    idle();

    // Reset state
    #12;
    chk("rst_wb_valid",  ip_wb_valid, 0);
    chk("rst_override",  ip_if_pc_override, 0);
    chk("rst_new_pc",    ip_if_new_pc, 0);
    chk("rst_fwd_valid", ip_ix_fwd_valid, 0);
    chk("rst_wb_result", ip_wb_result, 0);
    chk("rst_ready",     ix_ip_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ADD: 5 + 7 -> dst 3, visible at writeback three edges later
    drive(mk_alu(ALU_ADD, 64'd5, 64'd7, 5'd3, 64'h100), 1'b1);
    cycle();
    chk("add_fwd_s0", ip_ix_fwd_valid, 3'b001);
    idle();
    cycle();
    chk("add_fwd_s1", ip_ix_fwd_valid, 3'b010);
    cycle();
    chk("add_fwd_s2",  ip_ix_fwd_valid, 3'b100);
    chk("add_wbv",     ip_wb_valid, 1);
    chk("add_result",  ip_wb_result, 64'd12);
    chk("add_dst",     ip_wb_dst, 5'd3);
    cycle();

    // Truncate: 0x7FFFFFFF + 1 as a W op
    o = mk_alu(ALU_ADD, 64'h7FFF_FFFF, 64'd1, 5'd4, 64'h104);
    o.trunc = 1'b1;
    drive(o, 1'b1);
    cycle(); idle(); cycle(); cycle();
    chk("trunc_result", ip_wb_result, 64'hFFFF_FFFF_8000_0000);
    cycle();

    // Mispredicted BEQ: the next accepted op is wrong-path and vanishes
    o = mk_alu(ALU_SEQ, 64'd9, 64'd9, 5'd0, 64'h1000);
    o.wb_en = 1'b0; o.br_type = BT_BCOND; o.bp = 1'b0;
    o.base = 64'h1000; o.off = 21'h40;
    drive(o, 1'b1);
    cycle();
    chk("beq_override", ip_if_pc_override, 1);
    chk("beq_new_pc",   ip_if_new_pc, 64'h1040);
    drive(mk_alu(ALU_ADD, 64'd1, 64'd2, 5'd7, 64'h1004), 1'b1);
    cycle();
    chk("beq_pulse_end", ip_if_pc_override, 0);
    idle();
    repeat (4) cycle();

    // Correctly predicted JALR: no redirect, result pc+4
    o = mk_alu(ALU_ADD, 64'h3000, 64'd4, 5'd1, 64'h3000);
    o.br_type = BT_JALR; o.base = 64'h2003; o.off = 21'd0;
    o.bp = 1'b1; o.bt = 64'h2002;
    drive(o, 1'b1);
    cycle();
    chk("jalr_no_override", ip_if_pc_override, 0);
    idle(); cycle(); cycle();
    chk("jalr_result", ip_wb_result, 64'h3004);
    cycle();

    // Stall: three ops streamed, writeback stalls for four cycles
    for (int i = 0; i < 3; i++) begin
      drive(mk_alu(ALU_XOR, {$urandom, $urandom}, {$urandom, $urandom}, 5'(10 + i), 64'(32'h4000 + 4 * i)), 1'b1);
      cycle();
    end
    ip_wb_ready = 1'b0;
    drive(mk_alu(ALU_OR, 64'hF0, 64'h0F, 5'd20, 64'h400C), 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_ready", ix_ip_ready, 0);
      cycle();
    end
    ip_wb_ready = 1'b1;
    cycle();
    idle();
    repeat (5) cycle();

    // Flush with a full pipe and a mispredicting branch on the flush cycle
    for (int i = 0; i < 3; i++) begin
      drive(mk_alu(ALU_ADD, 64'(i), 64'd100, 5'(i + 1), 64'(32'h5000 + 4 * i)), 1'b1);
      cycle();
    end
    o = mk_alu(ALU_SEQ, 64'd1, 64'd1, 5'd0, 64'h500C);
    o.br_type = BT_BCOND; o.bp = 1'b0; o.base = 64'h6000; o.off = 21'h20;
    drive(o, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    chk("flush_fwd_valid", ip_ix_fwd_valid, 0);
    chk("flush_wb_valid",  ip_wb_valid, 0);
    chk("flush_override",  ip_if_pc_override, 0);
    repeat (3) cycle();

    // Random traffic with back-pressure and occasional flush
    repeat (300) begin
      random_op(o);
      drive(o, ($urandom_range(0, 3) != 0));
      ip_wb_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0; ip_wb_ready = 1'b1; idle();
    repeat (5) cycle();

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      drive(mk_alu(ALU_AND, {$urandom, $urandom}, {$urandom, $urandom}, 5'(i + 8), 64'(32'h7000 + 4 * i)), 1'b1);
      cycle();
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_valid",  ip_wb_valid, 0);
    chk("arst_fwd_valid", ip_ix_fwd_valid, 0);
    chk("arst_override",  ip_if_pc_override, 0);
    exp_q.delete();
    ovr_m = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (5) cycle();
    drive(mk_alu(ALU_SLL, 64'd3, 64'd4, 5'd9, 64'h8000), 1'b1);
    cycle(); idle();
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
